mux_nto1_pipe: RTL and testbench
================================

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter NCH, default 4, channel count; legal values 2, 4, 8, 16.
REQ-003 SHALL have derived localparam SELW = log2(NCH), the select and channel-index width.
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port: in_data  input  NCH*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port: in_valid  input  NCH  per-channel data-valid.
REQ-008 SHALL have port: in_ready  output  NCH  per-channel accept; combinational.
REQ-009 SHALL have port: sel  input  SELW  channel select in fixed mode.
REQ-010 SHALL have port: mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-011 SHALL have port: out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port: out_valid  output  1  out_data holds an unconsumed word.
REQ-013 SHALL have port: out_ready  input  1  downstream accept.
REQ-014 SHALL have port: out_ch  output  SELW  source channel index of out_data.

Function
REQ-015 SHALL implement one output register stage; load_en = !out_valid || out_ready.
REQ-016 SHALL give latency of exactly 1 cycle from input transfer to out_valid, with throughput of 1 word/cycle.
REQ-017 SHALL assert at most one in_ready bit per cycle: only the granted channel, and only when load_en=1.
REQ-018 SHALL define an input transfer as in_valid[g] && in_ready[g]; on transfer, out_data <= channel g data, out_ch <= g, out_valid <= 1.
REQ-019 SHALL grant g = sel in fixed mode, re-evaluated every cycle; sel changes while stalled SHALL NOT alter held out_data.
REQ-020 SHALL grant, in round-robin mode, the first channel with in_valid=1 searching ptr, ptr+1, ..., wrapping modulo NCH.
REQ-021 SHALL update the round-robin pointer ptr (SELW bits) to (g+1) mod NCH on each round-robin transfer; ptr SHALL hold when no transfer occurs or in fixed mode.
REQ-022 SHALL produce no grant and no transfer when no channel is valid in round-robin mode, with all in_ready=0.
REQ-023 SHALL clear out_valid when out_ready=1 and no transfer occurs in the same cycle.
REQ-024 SHALL, when out_ready=1 and a transfer occur in the same cycle, keep out_valid=1 and replace out_data/out_ch with the new word; no bubble.
REQ-025 SHALL hold out_data, out_ch and out_valid stable while out_valid=1 and out_ready=0, with in_ready=0 on all channels.
REQ-026 SHALL take a mode change effect on the grant in the same cycle, without disturbing a held output word.

Reset
REQ-027 SHALL, on rst_n low, immediately (asynchronously) set out_data=0, out_valid=0, out_ch=0, ptr=0.
REQ-028 SHALL force in_ready to all zeros while rst_n is low.
REQ-029 SHALL discard a word held at reset assertion; the first transfer after release follows normal rules from ptr=0.

Configuration
REQ-030 SHALL use macro MUX_NTO1_RR_EN: when defined, round-robin mode and ptr logic are built and mode functions per REQ-020..022.
REQ-031 SHALL, when MUX_NTO1_RR_EN is undefined, keep the mode port, ignore it, always use fixed-select behaviour, and instantiate no ptr register.

Verification (WIDTH=8, NCH=4)
REQ-032 SHALL cover reset: rst_n driven low mid-stream with out_valid=1 -> out_valid=0, out_data=0x00, out_ch=0 before next clock edge; in_ready=4'b0000.
REQ-033 SHALL cover fixed select: mode=0, sel=2, in_valid=4'b1111, ch2=0xC3, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xC3, out_ch=2, out_valid=1.
REQ-034 SHALL cover backpressure: out_valid=1, out_ready=0 for 3 cycles, sel toggled -> out_data/out_ch unchanged, in_ready=4'b0000; out_ready=1 -> new word loaded same edge, out_valid stays 1.
REQ-035 SHALL cover round-robin fairness: macro defined, mode=1, in_valid=4'b1111 constant, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-036 SHALL cover round-robin skip/wrap: mode=1, ptr=1, in_valid=4'b1001 constant -> out_ch sequence 3,0,3,0; in_valid=4'b0000 -> out_valid falls, ptr holds.
REQ-037 SHALL cover the build without the macro: mode=1, sel=1, in_valid=4'b1111 -> out_ch=1 every cycle (fixed behaviour).

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel multiplexer with a single registered output stage and valid/ready handshakes.
// Optional round-robin scan mode is built only when MUX_NTO1_RR_EN is defined.
module mux_nto1_pipe #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             load_en;
  logic [SELW-1:0]  grant_idx;
  logic             grant_vld;
  logic             xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = rst_n && load_en && grant_vld && (grant_idx == SELW'(gi));
    end
  endgenerate

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = in_valid[grant_idx] && in_ready[grant_idx];

`ifdef MUX_NTO1_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] cand;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant_idx = sel;
    grant_vld = 1'b1;
    cand      = '0;
    if (mode) begin
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
        cand = ptr_q + SELW'(i);
        if (in_valid[cand]) begin
          grant_idx = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (mode && xfer) begin
      ptr_d = grant_idx + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant_idx   = sel;
  assign grant_vld   = 1'b1;
`endif

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe (WIDTH=8, NCH=4): directed scenarios plus random
// traffic compared against a transaction-level model of the grant and output-register rules.
module tb_mux_nto1_pipe;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chan(input int k);
    return in_data[k*WIDTH +: WIDTH];
  endfunction

  function automatic bit rr_active();
`ifdef MUX_NTO1_RR_EN
    return mode;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  // One clock: check in_ready, predict the transaction, clock it, check the output register.
  task automatic step(input string tag);
    logic [3:0] exp_rdy;
    bit         has_grant;
    int         g;
    #1;
    exp_rdy   = 4'b0000;
    g         = int'(sel);
    has_grant = 1;
    if (rr_active()) begin
      has_grant = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!has_grant && in_valid[(m_ptr + k) % NCH]) begin
          has_grant = 1;
          g = (m_ptr + k) % NCH;
        end
      end
    end
    if (has_grant && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy[g] && in_valid[g]) begin
      m_data  = chan(g);
      m_ch    = g;
      m_valid = 1;
      if (rr_active()) m_ptr = (g + 1) % NCH;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    $display("%0t %s: in_valid=%b sel=%0d mode=%0d out_ready=%0d -> out_valid=%0d out_ch=%0d out_data=0x%02h",
             $time, tag, in_valid, sel, mode, out_ready, out_valid, out_ch, out_data);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, ".out_ch"}, 32'(out_ch), 32'(m_ch));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = {8'hD3, 8'hC3, 8'hB3, 8'hA3};
    in_valid  = 4'b1111;
    sel       = 2'd0;
    mode      = 1'b0;
    out_ready = 1'b1;
    model_reset();

    // Reset state, with every channel valid to show in_ready is forced low.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data", 32'(out_data), 32'h00);
    chk("reset.out_ch", 32'(out_ch), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'b0000);
    rst_n = 1'b1;

    // Fixed select of channel 2.
    sel = 2'd2;
    #1;
    chk("fixed.in_ready_const", 32'(in_ready), 32'b0100);
    step("fixed");
    chk("fixed.data_const", 32'(out_data), 32'hC3);
    chk("fixed.ch_const", 32'(out_ch), 32'd2);

    // Backpressure: held word stays put while sel toggles.
    out_ready = 1'b0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 3; i++) begin
      sel = (i % 2 == 0) ? 2'd1 : 2'd3;
      step("stall");
      chk("stall.data_const", 32'(out_data), 32'hC3);
      chk("stall.ch_const", 32'(out_ch), 32'd2);
    end
    out_ready = 1'b1;
    sel       = 2'd1;
    step("unstall");
    chk("unstall.valid_const", 32'(out_valid), 32'd1);
    chk("unstall.data_const", 32'(out_data), 32'h22);

`ifdef MUX_NTO1_RR_EN
    // Round-robin fairness from ptr=0 (fixed-mode traffic leaves ptr untouched).
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step("rr_fair");
      chk("rr_fair.ch_const", 32'(out_ch), 32'(i % 4));
    end
    // Skip and wrap from ptr=1 with only channels 0 and 3 valid.
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step("rr_wrap");
      chk("rr_wrap.ch_const", 32'(out_ch), (i % 2 == 0) ? 32'd3 : 32'd0);
    end
    in_valid = 4'b0000;
    step("rr_idle");
    chk("rr_idle.valid_const", 32'(out_valid), 32'd0);
    in_valid = 4'b1111;
    step("rr_ptr_hold");
    chk("rr_ptr_hold.ch_const", 32'(out_ch), 32'd1);
`else
    // Without round-robin support the mode input is ignored.
    mode     = 1'b1;
    sel      = 2'd1;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step("norr_fixed");
      chk("norr_fixed.ch_const", 32'(out_ch), 32'd1);
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      sel       = 2'($urandom_range(0, 3));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Asynchronous reset in the middle of a cycle while a word is held.
    mode      = 1'b0;
    sel       = 2'd3;
    in_valid  = 4'b1111;
    in_data   = {8'h9E, 8'h8D, 8'h7C, 8'h6B};
    out_ready = 1'b1;
    step("pre_reset");
    out_ready = 1'b0;
    chk("pre_reset.valid_const", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset.out_valid", 32'(out_valid), 32'd0);
    chk("async_reset.out_data", 32'(out_data), 32'h00);
    chk("async_reset.out_ch", 32'(out_ch), 32'd0);
    chk("async_reset.in_ready", 32'(in_ready), 32'b0000);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1110;
    out_ready = 1'b1;
    step("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
